// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control sequencer:
// instruction field widths, opcode/funct encodings, ALU select codes,
// the controller state enum and the decoded control bundle.
package proc_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned ALU_SEL_W = 3;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned IMM_W     = 16;

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;

  // R-type funct codes
  localparam logic [OP_W-1:0] FN_SLL  = 6'd0;
  localparam logic [OP_W-1:0] FN_SRL  = 6'd2;
  localparam logic [OP_W-1:0] FN_MULT = 6'd24;
  localparam logic [OP_W-1:0] FN_ADD  = 6'd32;
  localparam logic [OP_W-1:0] FN_AND  = 6'd36;
  localparam logic [OP_W-1:0] FN_OR   = 6'd37;
  localparam logic [OP_W-1:0] FN_NOR  = 6'd39;

  typedef enum logic [ALU_SEL_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_MULT = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_NOR  = 3'b101,
    ALU_SLL  = 3'b110,
    ALU_SRL  = 3'b111
  } alu_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } ctrl_state_e;

  // Decoded controls, registered once per instruction and held through WB.
  typedef struct packed {
    logic [REG_AW-1:0]  raddr1;
    logic [REG_AW-1:0]  raddr2;
    logic [REG_AW-1:0]  waddr;
    alu_sel_e           alu_sel;
    logic               alu_src_imm;
    logic [INSTR_W-1:0] imm_ext;
    logic               wb_sel;
    logic               is_mem;
    logic               is_store;
    logic               writes_rf;
  } ctrl_t;

  function automatic logic [INSTR_W-1:0] sext16(input logic [IMM_W-1:0] v);
    return {{(INSTR_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [INSTR_W-1:0] zext16(input logic [IMM_W-1:0] v);
    return {{(INSTR_W-IMM_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder.
// Ports:
//   instr_i   - latched 32-bit instruction word
//   ctrl_o    - decoded control bundle (all zero for unsupported encodings)
//   illegal_o - unsupported opcode or R-type funct
module ctrl_decode
  import proc_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output ctrl_t              ctrl_o,
  output logic               illegal_o
);

  logic [OP_W-1:0]   op;
  logic [OP_W-1:0]   funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] shamt;
  logic [IMM_W-1:0]  imm;

  assign op    = instr_i[31:26];
  assign rs    = instr_i[25:21];
  assign rt    = instr_i[20:16];
  assign rd    = instr_i[15:11];
  assign shamt = instr_i[10:6];
  assign funct = instr_i[5:0];
  assign imm   = instr_i[15:0];

  // Opcode/funct to control bundle lookup
  always_comb begin
    ctrl_o        = '0;
    illegal_o     = 1'b0;
    ctrl_o.raddr1 = rs;
    ctrl_o.raddr2 = rt;
    case (op)
      OP_RTYPE: begin
        ctrl_o.waddr     = rd;
        ctrl_o.writes_rf = 1'b1;
        case (funct)
          FN_ADD:  ctrl_o.alu_sel = ALU_ADD;
          FN_AND:  ctrl_o.alu_sel = ALU_AND;
          FN_MULT: ctrl_o.alu_sel = ALU_MULT;
          FN_OR:   ctrl_o.alu_sel = ALU_OR;
          FN_NOR:  ctrl_o.alu_sel = ALU_NOR;
          // Shifts take the shifted value from rt on port 1, shamt as operand B
          FN_SLL: begin
            ctrl_o.alu_sel     = ALU_SLL;
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.imm_ext     = INSTR_W'(shamt);
            ctrl_o.raddr1      = rt;
          end
          FN_SRL: begin
            ctrl_o.alu_sel     = ALU_SRL;
            ctrl_o.alu_src_imm = 1'b1;
            ctrl_o.imm_ext     = INSTR_W'(shamt);
            ctrl_o.raddr1      = rt;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI: begin
        ctrl_o.alu_sel     = ALU_ADD;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_ext     = sext16(imm);
        ctrl_o.waddr       = rt;
        ctrl_o.writes_rf   = 1'b1;
      end
      OP_ANDI: begin
        ctrl_o.alu_sel     = ALU_AND;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_ext     = zext16(imm);
        ctrl_o.waddr       = rt;
        ctrl_o.writes_rf   = 1'b1;
      end
      OP_ORI: begin
        ctrl_o.alu_sel     = ALU_OR;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_ext     = zext16(imm);
        ctrl_o.waddr       = rt;
        ctrl_o.writes_rf   = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_sel     = ALU_ADD;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_ext     = sext16(imm);
        ctrl_o.waddr       = rt;
        ctrl_o.writes_rf   = 1'b1;
        ctrl_o.wb_sel      = 1'b1;
        ctrl_o.is_mem      = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_sel     = ALU_ADD;
        ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.imm_ext     = sext16(imm);
        ctrl_o.is_mem      = 1'b1;
        ctrl_o.is_store    = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    // Unsupported encodings must never leak a write or memory request
    if (illegal_o) begin
      ctrl_o = '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS-subset datapath.
// Accepts one instruction per handshake in IDLE, then steps it through
// DECODE, EXEC, (MEM for loads/stores) and WB, driving register-file
// addresses/strobe, ALU select, immediate operand and memory requests.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   instr_valid/ready   - instruction handshake (ready only in IDLE)
//   instr               - instruction word, latched on accept
//   rf_raddr1/2, rf_waddr, rf_we, wb_sel - register-file controls
//   alu_sel, alu_src_imm, imm_ext        - ALU controls and immediate
//   mem_req, mem_we, mem_ack             - data memory handshake
//   done, illegal, bus_err               - completion pulse and status
//   retired_count       - legally completed instruction count (wraps)
module multicycle_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned RET_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic [REG_AW-1:0]    rf_raddr1,
  output logic [REG_AW-1:0]    rf_raddr2,
  output logic [REG_AW-1:0]    rf_waddr,
  output logic                 rf_we,
  output logic                 wb_sel,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 alu_src_imm,
  output logic [INSTR_W-1:0]   imm_ext,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic                 mem_ack,
  output logic                 done,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [RET_W-1:0]     retired_count
);

  localparam int unsigned     CNT_W    = 8;
  // Last wait-counter value before the timeout edge
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e         state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RET_W-1:0]    retired_q, retired_d;
  logic                instr_ready_q, instr_ready_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic                rf_we_q, rf_we_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;

  ctrl_t               dec_ctrl;
  logic                dec_illegal;

  ctrl_decode u_decode (
    .instr_i   (instr_q),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    ctrl_d        = ctrl_q;
    cnt_d         = cnt_q;
    retired_d     = retired_q;
    instr_ready_d = 1'b0;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    bus_err_d     = 1'b0;
    rf_we_d       = 1'b0;
    mem_req_d     = 1'b0;
    mem_we_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end else begin
          instr_ready_d = 1'b1;
        end
      end
      ST_DECODE: begin
        ctrl_d = dec_ctrl;
        if (dec_illegal) begin
          state_d   = ST_WB;
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctrl_q.is_mem) begin
          state_d   = ST_MEM;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          mem_we_d  = ctrl_q.is_store;
        end else begin
          state_d   = ST_WB;
          done_d    = 1'b1;
          rf_we_d   = ctrl_q.writes_rf && (ctrl_q.waddr != '0);
          retired_d = retired_q + RET_W'(1);
        end
      end
      ST_MEM: begin
        // Ack wins over a timeout falling in the same cycle
        if (mem_ack) begin
          state_d   = ST_WB;
          done_d    = 1'b1;
          rf_we_d   = ctrl_q.writes_rf && (ctrl_q.waddr != '0);
          retired_d = retired_q + RET_W'(1);
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_WB;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      ST_WB: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
      end
      default: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      ctrl_q        <= '0;
      cnt_q         <= '0;
      retired_q     <= '0;
      instr_ready_q <= 1'b1;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      rf_we_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      ctrl_q        <= ctrl_d;
      cnt_q         <= cnt_d;
      retired_q     <= retired_d;
      instr_ready_q <= instr_ready_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      bus_err_q     <= bus_err_d;
      rf_we_q       <= rf_we_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign instr_ready   = instr_ready_q;
  assign rf_raddr1     = ctrl_q.raddr1;
  assign rf_raddr2     = ctrl_q.raddr2;
  assign rf_waddr      = ctrl_q.waddr;
  assign rf_we         = rf_we_q;
  assign wb_sel        = ctrl_q.wb_sel;
  assign alu_sel       = ctrl_q.alu_sel;
  assign alu_src_imm   = ctrl_q.alu_src_imm;
  assign imm_ext       = ctrl_q.imm_ext;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign bus_err       = bus_err_q;
  assign retired_count = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the MIPS-subset datapath (register file, ALU, data memory, immediate units). It accepts one 32-bit instruction per handshake and decodes it. It then steps the instruction through DECODE, EXEC, MEM and WB, driving register-file addresses and enables, ALU select, immediate operand and memory requests. It sits between the instruction source and the datapath, and it owns every write enable so that no two writes overlap within an instruction.

Parameters:
RET_W, 16, width of retired-instruction counter
MEM_TIMEOUT, 15, max cycles waiting for mem_ack before bus error (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction available
instr_ready  out  1  controller can accept (IDLE only)
instr  in  32  instruction word, sampled when valid&&ready
rf_raddr1  out  5  register read port 1 address
rf_raddr2  out  5  register read port 2 address
rf_waddr  out  5  register write address
rf_we  out  1  register write strobe, single cycle
wb_sel  out  1  0 = ALU result, 1 = memory read data
alu_sel  out  3  ALU function code
alu_src_imm  out  1  ALU operand B = imm_ext instead of read data 2
imm_ext  out  32  extended immediate / shamt
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = store, valid while mem_req
mem_ack  in  1  memory completed request
done  out  1  one-cycle pulse, instruction complete
illegal  out  1  with done: unsupported opcode/funct
bus_err  out  1  with done: memory timeout
retired_count  out  RET_W  count of legally completed instructions

Behaviour:
- Reset: state IDLE; instr_ready=1; all other outputs 0; retired_count=0; latched instr=0. A reset in any state aborts the instruction, drops mem_req in the same edge, and does not pulse done.
- States: IDLE, DECODE, EXEC, MEM, WB.
- IDLE: instr_ready=1. On valid&&ready, latch instr and go to DECODE. instr_ready is 0 in all other states.
- DECODE: drive rf_raddr1=rs and rf_raddr2=rt. For SLL/SRL, rf_raddr1=rt. Unsupported encodings go to WB with illegal=1.
- Decoded controls (addresses, alu_sel, alu_src_imm, imm_ext, wb_sel, mem_we) are registered at the DECODE edge and held stable through WB.
- EXEC: ALU operands valid. Next state is MEM for LW/SW, otherwise WB.
- MEM: mem_req=1 and mem_we=(SW). Wait counter starts at 0 and increments each cycle without ack. On mem_ack, go to WB. If the counter reaches MEM_TIMEOUT without ack, drop mem_req and go to WB with bus_err=1. An ack arriving in the same cycle as timeout counts as success.
- WB: done=1 for one cycle. rf_we=1 only for writers (R-type, ADDI, ANDI, ORI, LW) with no illegal/bus_err and rf_waddr!=0. retired_count increments (wraps at 2^RET_W) only when neither illegal nor bus_err. Next state is IDLE.
- Latency (accept edge to done):
  - R-type and immediate ops: 3 cycles.
  - LW/SW: 4 cycles plus the number of cycles without ack.
  - Illegal: 2 cycles.
- Decode table (opcode/funct -> alu_sel, alu_src_imm, imm_ext, rf_waddr):
  - op0 f32 ADD -> 000, 0, -, rd
  - op0 f36 AND -> 010, 0, -, rd
  - op0 f24 MULT -> 001, 0, -, rd (low 32 bits)
  - op0 f37 OR -> 011, 0, -, rd
  - op0 f39 NOR -> 101, 0, -, rd
  - op0 f0 SLL -> 110, 1, zext(shamt[10:6]), rd
  - op0 f2 SRL -> 111, 1, zext(shamt[10:6]), rd
  - op8 ADDI -> 000, 1, sext(imm16), rt
  - op12 ANDI -> 010, 1, zext(imm16), rt
  - op13 ORI -> 011, 1, zext(imm16), rt
  - op35 LW -> 000, 1, sext, rt, wb_sel=1
  - op43 SW -> 000, 1, sext, no write
- instr_valid asserted while busy is ignored (not queued).
- The busy interval ends in WB; the next accept happens at the earliest in the following IDLE cycle.

Decomposition:
- Package proc_pkg: opcode and funct constants, ALU_Sel codes (000 ADD, 001 MULT, 010 AND, 011 OR, 101 NOR, 110 SLL, 111 SRL), ctrl state enum.
- One combinational sub-module ctrl_decode: instr -> control bundle plus illegal flag. The FSM, timeout counter and retired counter live in multicycle_ctrl.

Test Plan:
- ADDI 0x2109FFFF (rs=8, rt=9, imm=-1), accepted at cycle 0 -> cycle 3: done=1, rf_we=1, rf_waddr=9, alu_sel=000, imm_ext=0xFFFFFFFF, retired_count=1.
- SW 0xAD0A0004 with mem_ack at 3rd MEM cycle -> mem_req=1 and mem_we=1 for exactly 3 cycles; done one cycle later; rf_we never 1.
- LW 0x8D0B0008 with mem_ack never asserted, MEM_TIMEOUT=15 -> mem_req drops after 15 cycles; done=1, bus_err=1, rf_we=0, retired_count unchanged.
- Illegal 0xFC000000 (op 63) -> done with illegal=1 at cycle 2; rf_we=0, mem_req=0; next instruction accepted normally.
- SLL 0x00085080 (rt=8, rd=10, shamt=2) -> rf_raddr1=8, alu_sel=110, imm_ext=2; rf_we=1 to rd 10. ADD writing rd=0 -> done with rf_we=0.
- rst asserted mid-MEM on LW -> next cycle IDLE, mem_req=0, done=0, instr_ready=1, retired_count=0.
